// File: rtl/ext_bus_pkg.sv
// Shared command codes, EXT_BUS bit map and FSM state type for the external bus host.
package ext_bus_pkg;

  localparam int BUS_W       = 36;
  localparam int DOUT_LO     = 0;
  localparam int DOUT_HI     = 15;
  localparam int DIN_LO      = 16;
  localparam int DIN_HI      = 31;
  localparam int DOUT_EN_BIT = 32;
  localparam int STROBE_BIT  = 33;
  localparam int ENABLE_BIT  = 34;

  localparam logic [15:0] CD_GET = 16'h0034;
  localparam logic [15:0] CD_SET = 16'h0035;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STROBE,
    ST_SAMPLE,
    ST_GAP,
    ST_END
  } host_state_t;

  // Payload word for bus slot idx of a CD_SET; slot 0 is the command itself.
  function automatic logic [15:0] tx_word(input logic [47:0] msg, input logic [1:0] idx);
    case (idx)
      2'd1:    return msg[15:0];
      2'd2:    return msg[31:16];
      2'd3:    return msg[47:32];
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/ext_poll_timer.sv
// Free-running poll timer: one-cycle tick every INTERVAL clk_sys cycles.
// Only instantiated when EXT_BUS_HOST_AUTOPOLL_EN is defined.
module ext_poll_timer #(
  parameter int INTERVAL = 1024
) (
  input  logic clk_sys,
  input  logic reset_n,
  output logic tick
);

  localparam logic [31:0] LAST = 32'(INTERVAL - 1);

  logic [31:0] count;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      count <= 32'd0;
      tick  <= 1'b0;
    end else if (count == LAST) begin
      count <= 32'd0;
      tick  <= 1'b1;
    end else begin
      count <= count + 32'd1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/ext_bus_host.sv
// Host for the strobed 4-word EXT_BUS device protocol (CD_GET polls, CD_SET writes).
// Define EXT_BUS_HOST_AUTOPOLL_EN to add a periodic CD_GET every POLL_INTERVAL cycles.
module ext_bus_host
  import ext_bus_pkg::*;
#(
  parameter int POLL_INTERVAL = 1024,
  parameter int STROBE_GAP    = 1,
  parameter int IDLE_GAP      = 2
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  inout  wire  [BUS_W-1:0]  EXT_BUS,
  input  logic              tx_valid,
  input  logic [47:0]       tx_data,
  output logic              tx_ready,
  input  logic              poll_req,
  output logic              rx_valid,
  output logic [47:0]       rx_data,
  output logic              nak
);

  localparam logic [15:0] GAP_LAST = 16'(STROBE_GAP - 1);
  localparam logic [15:0] END_LAST = 16'(IDLE_GAP - 1);

  host_state_t state, state_nxt;
  logic [15:0] gap_cnt;
  logic [1:0]  word_idx;
  logic        is_set;
  logic        ready_q;
  logic        poll_pend;
  logic        poll_tick;
  logic [47:0] tx_buf;
  logic [15:0] io_din;
  logic [15:0] word1, word2;
  logic [7:0]  req_buf, last_req;
  logic        io_strobe, io_enable;
  logic        launch_set, launch_get, last_word, step_word;
  logic [15:0] io_dout;
  logic        dout_en;

  assign io_dout                    = EXT_BUS[DOUT_HI:DOUT_LO];
  assign dout_en                    = EXT_BUS[DOUT_EN_BIT];
  assign EXT_BUS[DIN_HI:DIN_LO]     = io_din;
  assign EXT_BUS[STROBE_BIT]        = io_strobe;
  assign EXT_BUS[ENABLE_BIT]        = io_enable;
  assign EXT_BUS[BUS_W-1]           = 1'bz;

`ifdef EXT_BUS_HOST_AUTOPOLL_EN
  ext_poll_timer #(
    .INTERVAL(POLL_INTERVAL)
  ) u_poll_timer (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .tick    (poll_tick)
  );
`else
  assign poll_tick = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (launch_set || launch_get) state_nxt = ST_STROBE;
      ST_STROBE: state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = last_word ? ST_END : ST_GAP;
      ST_GAP:    if (step_word) state_nxt = ST_STROBE;
      ST_END:    if (gap_cnt == END_LAST) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // A pending tx wins over a poll; a fresh poll_req in IDLE launches without a wait cycle.
  always_comb begin
    tx_ready   = 1'b0;
    io_strobe  = 1'b0;
    io_enable  = 1'b0;
    launch_set = 1'b0;
    launch_get = 1'b0;
    last_word  = 1'b0;
    step_word  = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_ready   = ready_q;
        launch_set = ready_q && tx_valid;
        launch_get = ready_q && !tx_valid && (poll_pend || poll_req);
      end
      ST_STROBE: begin
        io_enable = 1'b1;
        io_strobe = 1'b1;
      end
      ST_SAMPLE: begin
        io_enable = 1'b1;
        last_word = (word_idx == 2'd3) || ((word_idx == 2'd0) && !dout_en);
      end
      ST_GAP: begin
        io_enable = 1'b1;
        step_word = (gap_cnt == GAP_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                                gap_cnt <= 16'd0;
    else if (state_nxt != state)                 gap_cnt <= 16'd0;
    else if (state == ST_GAP || state == ST_END) gap_cnt <= gap_cnt + 16'd1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ready_q   <= 1'b0;
      poll_pend <= 1'b0;
      is_set    <= 1'b0;
      tx_buf    <= 48'd0;
      word_idx  <= 2'd0;
      io_din    <= 16'd0;
      req_buf   <= 8'd0;
      word1     <= 16'd0;
      word2     <= 16'd0;
      last_req  <= 8'd0;
      rx_data   <= 48'd0;
      rx_valid  <= 1'b0;
      nak       <= 1'b0;
    end else begin
      ready_q  <= 1'b1;
      rx_valid <= 1'b0;
      nak      <= 1'b0;

      if (launch_get)                poll_pend <= 1'b0;
      else if (poll_req || poll_tick) poll_pend <= 1'b1;

      if (launch_set || launch_get) begin
        is_set   <= launch_set;
        word_idx <= 2'd0;
        io_din   <= launch_set ? CD_SET : CD_GET;
        if (launch_set) tx_buf <= tx_data;
      end

      if (state == ST_GAP && step_word) begin
        word_idx <= word_idx + 2'd1;
        io_din   <= is_set ? tx_word(tx_buf, word_idx + 2'd1) : 16'h0000;
      end

      if (state == ST_SAMPLE && word_idx == 2'd0 && !dout_en) nak <= 1'b1;

      // The device counter decides whether words 1..3 form a new message.
      if (state == ST_SAMPLE && !is_set) begin
        case (word_idx)
          2'd0: req_buf <= io_dout[7:0];
          2'd1: word1   <= io_dout;
          2'd2: word2   <= io_dout;
          default: begin
            if (req_buf != last_req) begin
              rx_data  <= {io_dout, word2, word1};
              last_req <= req_buf;
              rx_valid <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ext_bus_host.sv
// Self-checking bench for ext_bus_host: device model on EXT_BUS plus a message-level reference model.
module tb_ext_bus_host;

  localparam int STROBE_GAP = 1;
  localparam int IDLE_GAP   = 2;
  localparam int BUDGET     = 200;
  localparam int FULL_HIGH  = 4 * 2 + 3 * STROBE_GAP;

  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b1;
  wire  [35:0] ext_bus;
  logic        tx_valid = 1'b0;
  logic [47:0] tx_data  = 48'd0;
  logic        tx_ready;
  logic        poll_req = 1'b0;
  logic        rx_valid;
  logic [47:0] rx_data;
  logic        nak;

  logic [15:0] dev_dout = 16'd0;
  logic        dev_en   = 1'b1;
  logic [15:0] resp [4];

  assign ext_bus[15:0] = dev_dout;
  assign ext_bus[32]   = dev_en;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] din_q [$];
  int          rx_cnt = 0, nak_cnt = 0;
  int          low_run = 0, high_run = 0, last_high_run = 0, rise_low_run = 0;
  int          dev_idx = 0;
  logic        prev_en = 1'b0;
  logic [7:0]  model_last;
  logic [47:0] exp_rx;

  always #5 clk_sys = ~clk_sys;

  ext_bus_host #(
    .POLL_INTERVAL (1024),
    .STROBE_GAP    (STROBE_GAP),
    .IDLE_GAP      (IDLE_GAP)
  ) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .EXT_BUS  (ext_bus),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .poll_req (poll_req),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .nak      (nak)
  );

  // Device model and bus monitor, sampled mid-cycle.
  always @(negedge clk_sys) begin : monitor
    logic en;
    en = ext_bus[34];
    if (en && !prev_en) begin
      rise_low_run = low_run;
      high_run     = 0;
    end
    if (!en && prev_en) last_high_run = high_run;
    if (en) begin
      high_run = high_run + 1;
      low_run  = 0;
    end else begin
      low_run = low_run + 1;
      dev_idx = 0;
    end
    prev_en = en;
    if (ext_bus[33]) begin
      din_q.push_back(ext_bus[31:16]);
      dev_dout = resp[dev_idx];
      if (dev_idx < 3) dev_idx = dev_idx + 1;
    end
    if (rx_valid) rx_cnt = rx_cnt + 1;
    if (nak)      nak_cnt = nak_cnt + 1;
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] din_at(input int i);
    if (i < din_q.size()) return din_q[i];
    return 16'hxxxx;
  endfunction

  task automatic wait_ready(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk_sys);
      #1;
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_output({tag, "_done"}, 64'(ok), 64'd1);
  endtask

  task automatic clear_log();
    din_q.delete();
    rx_cnt  = 0;
    nak_cnt = 0;
  endtask

  // Reference: a new message is delivered only when the counter differs from the last one delivered.
  function automatic int model_get(input logic [7:0] cnt, input logic [15:0] r1, r2, r3);
    if (dev_en && cnt != model_last) begin
      exp_rx     = {r3, r2, r1};
      model_last = cnt;
      return 1;
    end
    return 0;
  endfunction

  task automatic set_resp(input logic [7:0] cnt, input logic [15:0] r1, r2, r3);
    resp[0] = {8'h00, cnt};
    resp[1] = r1;
    resp[2] = r2;
    resp[3] = r3;
  endtask

  task automatic run_get(input logic [7:0] cnt, input logic [15:0] r1, r2, r3, input string tag);
    int exp_pulses;
    set_resp(cnt, r1, r2, r3);
    clear_log();
    exp_pulses = model_get(cnt, r1, r2, r3);
    poll_req = 1'b1;
    @(posedge clk_sys);
    #1;
    poll_req = 1'b0;
    wait_ready(tag);
    check_output({tag, "_rx_pulses"}, 64'(rx_cnt), 64'(exp_pulses));
    check_output({tag, "_rx_data"}, 64'(rx_data), 64'(exp_rx));
    check_output({tag, "_strobes"}, 64'(din_q.size()), dev_en ? 64'd4 : 64'd1);
    check_output({tag, "_word0"}, 64'(din_at(0)), 64'h34);
    check_output({tag, "_nak"}, 64'(nak_cnt), dev_en ? 64'd0 : 64'd1);
    check_output({tag, "_en_high"}, 64'(last_high_run), dev_en ? 64'(FULL_HIGH) : 64'd2);
    check_output({tag, "_en_low"}, 64'(low_run), 64'(IDLE_GAP + 1));
  endtask

  task automatic check_set_words(input logic [47:0] d, input int base, input string tag);
    check_output({tag, "_w0"}, 64'(din_at(base)),     64'h35);
    check_output({tag, "_w1"}, 64'(din_at(base + 1)), 64'(d[15:0]));
    check_output({tag, "_w2"}, 64'(din_at(base + 2)), 64'(d[31:16]));
    check_output({tag, "_w3"}, 64'(din_at(base + 3)), 64'(d[47:32]));
  endtask

  task automatic run_set(input logic [47:0] d, input string tag);
    clear_log();
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk_sys);
    #1;
    tx_valid = 1'b0;
    wait_ready(tag);
    check_output({tag, "_strobes"}, 64'(din_q.size()), 64'd4);
    check_set_words(d, 0, tag);
    check_output({tag, "_rx_pulses"}, 64'(rx_cnt), 64'd0);
    check_output({tag, "_rx_data"}, 64'(rx_data), 64'(exp_rx));
    check_output({tag, "_en_high"}, 64'(last_high_run), 64'(FULL_HIGH));
    check_output({tag, "_en_low"}, 64'(low_run), 64'(IDLE_GAP + 1));
  endtask

  initial begin
    logic [47:0] d;
    logic [7:0]  c;
    bit          ok;
    int          exp_pulses;

    set_resp(8'h00, 16'h0, 16'h0, 16'h0);

    // Asynchronous reset with the clock mid-cycle.
    #2 reset_n = 1'b0;
    #1;
    check_output("rst_enable", 64'(ext_bus[34]), 64'd0);
    check_output("rst_strobe", 64'(ext_bus[33]), 64'd0);
    check_output("rst_din", 64'(ext_bus[31:16]), 64'd0);
    check_output("rst_rx_valid", 64'(rx_valid), 64'd0);
    check_output("rst_nak", 64'(nak), 64'd0);
    check_output("rst_rx_data", 64'(rx_data), 64'd0);
    check_output("rst_tx_ready", 64'(tx_ready), 64'd0);
    #20 reset_n = 1'b1;
    #1;
    check_output("rel_tx_ready_before_edge", 64'(tx_ready), 64'd0);
    @(posedge clk_sys);
    #1;
    check_output("rel_tx_ready_after_edge", 64'(tx_ready), 64'd1);
    model_last = 8'h00;
    exp_rx     = 48'd0;

    $display("[TB] directed CD_GET / CD_SET");
    run_get(8'h01, 16'h0035, 16'h0007, 16'h0000, "get_new");
    check_output("get_new_value", 64'(rx_data), 64'h0000_0007_0035);
    run_get(8'h01, 16'h1111, 16'h2222, 16'h3333, "get_same");
    run_set(48'h0000_0012_0036, "set_fixed");

    $display("[TB] tx and poll in the same cycle");
    d = 48'hA5A5_5A5A_C3C3;
    set_resp(8'h05, 16'hBEEF, 16'hCAFE, 16'h1234);
    clear_log();
    exp_pulses = model_get(8'h05, 16'hBEEF, 16'hCAFE, 16'h1234);
    tx_valid = 1'b1;
    tx_data  = d;
    poll_req = 1'b1;
    @(posedge clk_sys);
    #1;
    tx_valid = 1'b0;
    poll_req = 1'b0;
    wait_ready("both_first");
    wait_ready("both_second");
    check_output("both_strobes", 64'(din_q.size()), 64'd8);
    check_set_words(d, 0, "both_set");
    check_output("both_get_w0", 64'(din_at(4)), 64'h34);
    check_output("both_gap", 64'(rise_low_run), 64'(IDLE_GAP + 1));
    check_output("both_rx_pulses", 64'(rx_cnt), 64'(exp_pulses));
    check_output("both_rx_data", 64'(rx_data), 64'(exp_rx));

    $display("[TB] device refuses command");
    dev_en = 1'b0;
    run_get(8'h77, 16'h0BAD, 16'h0BAD, 16'h0BAD, "nak");
    dev_en = 1'b1;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        c = ($urandom_range(0, 2) == 0) ? model_last : 8'($urandom);
        run_get(c, 16'($urandom), 16'($urandom), 16'($urandom), "rnd_get");
      end else begin
        d = {16'($urandom), 16'($urandom), 16'($urandom)};
        run_set(d, "rnd_set");
      end
    end
    run_get(model_last + 8'h01, 16'($urandom), 16'($urandom), 16'($urandom), "rnd_wrap");
    run_get(8'hFF, 16'h00FF, 16'h0000, 16'hFFFF, "wrap_ff");
    run_get(8'h00, 16'h0A0A, 16'h0B0B, 16'h0C0C, "wrap_00");

    $display("[TB] reset during word 2 of CD_GET");
    set_resp(8'h99, 16'h1357, 16'h2468, 16'h9BDF);
    clear_log();
    poll_req = 1'b1;
    @(posedge clk_sys);
    #1;
    poll_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk_sys);
      #1;
      if (din_q.size() >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    check_output("mid_reached_word2", 64'(ok), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check_output("mid_enable", 64'(ext_bus[34]), 64'd0);
    check_output("mid_strobe", 64'(ext_bus[33]), 64'd0);
    check_output("mid_din", 64'(ext_bus[31:16]), 64'd0);
    check_output("mid_rx_data", 64'(rx_data), 64'd0);
    check_output("mid_tx_ready", 64'(tx_ready), 64'd0);
    repeat (2) @(posedge clk_sys);
    #3 reset_n = 1'b1;
    model_last = 8'h00;
    exp_rx     = 48'd0;
    @(posedge clk_sys);
    #1;
    check_output("mid_rel_tx_ready", 64'(tx_ready), 64'd1);
    check_output("mid_rx_pulses", 64'(rx_cnt), 64'd0);
    check_output("mid_nak", 64'(nak_cnt), 64'd0);
    run_get(8'h99, 16'h1357, 16'h2468, 16'h9BDF, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_bus_host.md
EXT_BUS_HOST -- requirements
Module: ext_bus_host

Interface
REQ-001 SHALL have parameter POLL_INTERVAL, default 1024; clk_sys cycles between automatic CD_GET polls.
REQ-002 SHALL have parameter STROBE_GAP, default 1; idle cycles between consecutive strobes, minimum 1.
REQ-003 SHALL have parameter IDLE_GAP, default 2; cycles io_enable stays low between transactions, minimum 1.
REQ-004 SHALL have port: clk_sys  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port: reset_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port: EXT_BUS  inout  36  device bus; host drives [31:16] io_din, [33] io_strobe and [34] io_enable; host samples [15:0] io_dout and [32] dout_en; all other bits high-Z.
REQ-007 SHALL have port: tx_valid  input  1  48-bit message offered for CD_SET.
REQ-008 SHALL have port: tx_data  input  48  CD_SET payload, word 1 = [15:0].
REQ-009 SHALL have port: tx_ready  output  1  high in IDLE only; a message is accepted when tx_valid and tx_ready are both high.
REQ-010 SHALL have port: poll_req  input  1  one-cycle request for an immediate CD_GET.
REQ-011 SHALL have port: rx_valid  output  1  one-cycle pulse when a new device message is captured.
REQ-012 SHALL have port: rx_data  output  48  last captured device message; held between pulses.
REQ-013 SHALL have port: nak  output  1  one-cycle pulse when dout_en is low after a command word.

Function
REQ-014 SHALL implement states IDLE, STROBE, SAMPLE, GAP and END.
- STROBE: io_strobe high for exactly 1 cycle.
- SAMPLE: 1 cycle after the strobe; capture io_dout, then wait STROBE_GAP cycles.
- END: io_enable low, counted for IDLE_GAP cycles, then IDLE.
REQ-015 SHALL raise io_enable on leaving IDLE and hold it high through the last SAMPLE of the transaction.
REQ-016 SHALL drive word 0 = command (CD_GET 16'h34, CD_SET 16'h35), then words 1..3; each word is stable from its strobe cycle to the next strobe.
REQ-017 SHALL on CD_GET read 4 words.
- Word 0 response [7:0] = device request counter.
- Words 1..3 responses form rx_data [15:0], [31:16], [47:32].
REQ-018 SHALL keep last_req (8 bits); when the word-0 counter differs from last_req at END entry, update rx_data and last_req and pulse rx_valid; otherwise leave rx_data unchanged with no pulse.
REQ-019 SHALL on CD_SET drive tx_data words 1..3 (sent as io_din) and capture nothing.
REQ-020 SHALL sample dout_en in the SAMPLE after word 0; if low, pulse nak, skip words 1..3 and go to END.
REQ-021 SHALL give priority to a pending tx over a pending poll when both are present in IDLE; the deferred poll stays pending (1-bit flag).
REQ-022 SHALL treat poll_req arriving outside IDLE as pending; multiple such requests merge into one.
REQ-023 SHALL compare the request counter modulo 256; wrap-around from 8'hFF to 8'h00 counts as a change.

Reset
REQ-024 SHALL on reset_n low, immediately:
- io_enable, io_strobe, io_din, rx_valid, nak = 0; rx_data = 0.
- last_req = 0; pending poll cleared; poll timer = 0.
- state = IDLE; tx_ready is high only from the first clk_sys edge after release.
REQ-025 SHALL, on reset mid-transaction, abandon the transaction without emitting rx_valid; a tx not yet accepted stays offered.

Configuration
REQ-026 SHALL, when EXT_BUS_HOST_AUTOPOLL_EN is defined, run a free-running timer that sets the pending poll every POLL_INTERVAL cycles.
REQ-027 SHALL, without EXT_BUS_HOST_AUTOPOLL_EN, poll only on poll_req, with no timer logic present.

Structure
REQ-028 SHALL take CD_GET, CD_SET and the EXT_BUS bit positions (din 31:16, dout 15:0, dout_en 32, strobe 33, enable 34) from shared package ext_bus_pkg.
REQ-029 SHALL place the poll timer in one sub-module, ext_poll_timer, instantiated only under EXT_BUS_HOST_AUTOPOLL_EN.

Verification
REQ-030 SHALL cover: device model counter 8'h01 with words 16'h0035, 16'h0007, 16'h0000 on a CD_GET -> rx_valid once, rx_data 48'h0000_0007_0035.
REQ-031 SHALL cover: a second CD_GET with counter still 8'h01 -> no rx_valid; rx_data unchanged.
REQ-032 SHALL cover: tx_data 48'h0000_0012_0036 -> io_din sequence 16'h35, 16'h0036, 16'h0012, 16'h0000, one strobe per word, then io_enable low for 2 cycles.
REQ-033 SHALL cover: tx_valid and poll_req in the same IDLE cycle -> CD_SET first, CD_GET immediately after END.
REQ-034 SHALL cover: dout_en held 0 -> nak pulse after word 0; io_enable drops; only 1 strobe issued.
REQ-035 SHALL cover: reset_n asserted during word 2 of a CD_GET -> all outputs 0 asynchronously; no rx_valid; next poll restarts from word 0.
